bsg_dmc_ui_arbiter: RTL and testbench



---
 rtl/bsg_dmc_ui_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_bsg_dmc_ui_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_dmc_ui_arbiter.sv
// Shares one bsg_dmc UI command/write/read channel set between num_ports_p requesters.
// Round-robin by default; define BSG_DMC_UI_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module bsg_dmc_ui_arbiter #(
    parameter int num_ports_p        = 2,
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 64,
    parameter int burst_data_width_p = 256,
    parameter int tag_fifo_els_p     = 4
) (
    input  logic                                      ui_clk_i,
    input  logic                                      ui_clk_sync_rst_i,

    input  logic [num_ports_p-1:0]                    req_v_i,
    input  logic [num_ports_p*3-1:0]                  req_cmd_i,
    input  logic [num_ports_p*ui_addr_width_p-1:0]    req_addr_i,
    output logic [num_ports_p-1:0]                    req_ready_o,

    input  logic [num_ports_p-1:0]                    wdata_v_i,
    input  logic [num_ports_p*ui_data_width_p-1:0]    wdata_i,
    input  logic [num_ports_p*(ui_data_width_p/8)-1:0] wmask_i,
    output logic [num_ports_p-1:0]                    wdata_ready_o,

    output logic [num_ports_p-1:0]                    rdata_v_o,
    output logic [ui_data_width_p-1:0]                rdata_o,
    output logic                                      rdata_end_o,

    output logic [ui_addr_width_p-1:0]                app_addr_o,
    output logic [2:0]                                app_cmd_o,
    output logic                                      app_en_o,
    input  logic                                      app_rdy_i,

    output logic                                      app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                app_wdf_data_o,
    output logic [ui_data_width_p/8-1:0]              app_wdf_mask_o,
    output logic                                      app_wdf_end_o,
    input  logic                                      app_wdf_rdy_i,

    input  logic                                      app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                app_rd_data_i,
    input  logic                                      app_rd_data_end_i
);

    localparam int burst_len_lp  = burst_data_width_p / ui_data_width_p;
    localparam int mask_w_lp     = ui_data_width_p / 8;
    localparam int port_w_lp     = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
    localparam int beat_w_lp     = (burst_len_lp > 1) ? $clog2(burst_len_lp) : 1;
    localparam int tag_ptr_w_lp  = (tag_fifo_els_p > 1) ? $clog2(tag_fifo_els_p) : 1;
    localparam int tag_cnt_w_lp  = $clog2(tag_fifo_els_p + 1);

    localparam logic [2:0] cmd_wr_lp = 3'b000;
    localparam logic [2:0] cmd_rd_lp = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2
    } state_e;

    state_e                   state_r, state_n;
    logic [port_w_lp-1:0]     grant_r, grant_n;
    logic [port_w_lp-1:0]     sel;
    logic [beat_w_lp-1:0]     beat_r, beat_n;

    logic [2:0]               cur_cmd;
    logic [ui_addr_width_p-1:0] cur_addr;
    logic [ui_data_width_p-1:0] cur_wdata;
    logic [mask_w_lp-1:0]     cur_wmask;
    logic                     cmd_is_wr, cmd_is_rd;
    logic                     cmd_en, cmd_fire;
    logic                     wr_v, beat_fire, beat_last;

    logic [port_w_lp-1:0]     tag_mem [tag_fifo_els_p];
    logic [tag_ptr_w_lp-1:0]  tag_wptr_r, tag_rptr_r;
    logic [tag_cnt_w_lp-1:0]  tag_cnt_r;
    logic                     tag_full, tag_empty, tag_push, tag_pop;
    logic [port_w_lp-1:0]     tag_head;
    logic                     rd_ok;

    function automatic logic [tag_ptr_w_lp-1:0] tag_next(input logic [tag_ptr_w_lp-1:0] p);
        return (p == tag_ptr_w_lp'(tag_fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef BSG_DMC_UI_ARB_FIXED_PRIORITY_EN
    // Lowest-index requester wins; scanning downward leaves the lowest hit in sel.
    always_comb begin
        sel = '0;
        for (int i = num_ports_p - 1; i >= 0; i--) begin
            if (req_v_i[port_w_lp'(i)]) sel = port_w_lp'(i);
        end
    end
`else
    logic [port_w_lp-1:0] ptr_r;
    logic [port_w_lp-1:0] cand_idx;
    logic                 found;
    logic                 xact_done;
    int                   cand;

    function automatic logic [port_w_lp-1:0] next_port(input logic [port_w_lp-1:0] g);
        return (g == port_w_lp'(num_ports_p - 1)) ? '0 : g + 1'b1;
    endfunction

    // First asserted port at or after the pointer, wrapping around.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < num_ports_p; i++) begin
            cand = int'(ptr_r) + i;
            if (cand >= num_ports_p) cand = cand - num_ports_p;
            cand_idx = port_w_lp'(cand);
            if (!found && req_v_i[cand_idx]) begin
                sel   = cand_idx;
                found = 1'b1;
            end
        end
    end

    assign xact_done = (cmd_fire & ~cmd_is_wr) | (beat_fire & beat_last);

    always_ff @(posedge ui_clk_i) begin
        if (ui_clk_sync_rst_i) ptr_r <= '0;
        else if (xact_done)    ptr_r <= next_port(grant_r);
    end
`endif

    assign cur_cmd   = req_cmd_i[int'(grant_r)*3 +: 3];
    assign cur_addr  = req_addr_i[int'(grant_r)*ui_addr_width_p +: ui_addr_width_p];
    assign cur_wdata = wdata_i[int'(grant_r)*ui_data_width_p +: ui_data_width_p];
    assign cur_wmask = wmask_i[int'(grant_r)*mask_w_lp +: mask_w_lp];
    assign cmd_is_wr = (cur_cmd == cmd_wr_lp);
    assign cmd_is_rd = (cur_cmd == cmd_rd_lp);

    // A read may only issue while there is room to remember who asked for it.
    assign cmd_en    = (state_r == CMD) & req_v_i[grant_r] & (cmd_is_wr | ~tag_full);
    assign cmd_fire  = cmd_en & app_rdy_i;
    assign wr_v      = (state_r == WDATA) & wdata_v_i[grant_r];
    assign beat_fire = wr_v & app_wdf_rdy_i;
    assign beat_last = (beat_r == beat_w_lp'(burst_len_lp - 1));

    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        beat_n  = beat_r;
        case (state_r)
            IDLE: begin
                if (|req_v_i) begin
                    grant_n = sel;
                    state_n = CMD;
                end
            end
            CMD: begin
                if (cmd_fire) begin
                    if (cmd_is_wr) begin
                        beat_n  = '0;
                        state_n = WDATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            WDATA: begin
                if (beat_fire) begin
                    beat_n = beat_r + 1'b1;
                    if (beat_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_clk_sync_rst_i) begin
            state_r <= IDLE;
            grant_r <= '0;
            beat_r  <= '0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            beat_r  <= beat_n;
        end
    end

    assign app_en_o       = cmd_en;
    assign app_addr_o     = (state_r == CMD) ? cur_addr : '0;
    assign app_cmd_o      = (state_r == CMD) ? cur_cmd : '0;
    assign app_wdf_wren_o = wr_v;
    assign app_wdf_end_o  = wr_v & beat_last;
    assign app_wdf_data_o = (state_r == WDATA) ? cur_wdata : '0;
    assign app_wdf_mask_o = (state_r == WDATA) ? cur_wmask : '0;

    always_comb begin
        req_ready_o   = '0;
        wdata_ready_o = '0;
        if (cmd_fire)  req_ready_o[grant_r]   = 1'b1;
        if (beat_fire) wdata_ready_o[grant_r] = 1'b1;
    end

    // In-order tag FIFO: one entry per outstanding read burst, holding the issuing port.
    assign tag_full  = (tag_cnt_r == tag_cnt_w_lp'(tag_fifo_els_p));
    assign tag_empty = (tag_cnt_r == '0);
    assign tag_push  = cmd_fire & cmd_is_rd;
    assign rd_ok     = app_rd_data_valid_i & ~tag_empty;
    assign tag_pop   = rd_ok & app_rd_data_end_i;
    assign tag_head  = tag_mem[tag_rptr_r];

    always_ff @(posedge ui_clk_i) begin
        if (tag_push) tag_mem[tag_wptr_r] <= grant_r;
    end

    always_ff @(posedge ui_clk_i) begin
        if (ui_clk_sync_rst_i) begin
            tag_wptr_r <= '0;
            tag_rptr_r <= '0;
            tag_cnt_r  <= '0;
        end else begin
            if (tag_push) tag_wptr_r <= tag_next(tag_wptr_r);
            if (tag_pop)  tag_rptr_r <= tag_next(tag_rptr_r);
            tag_cnt_r <= tag_cnt_r + tag_cnt_w_lp'(tag_push) - tag_cnt_w_lp'(tag_pop);
        end
    end

    always_comb begin
        rdata_v_o = '0;
        if (rd_ok) rdata_v_o[tag_head] = 1'b1;
    end

    assign rdata_o     = app_rd_data_i;
    assign rdata_end_o = app_rd_data_end_i;

`ifndef SYNTHESIS
    // Read data with no outstanding read means the controller and this block disagree.
    always_ff @(posedge ui_clk_i) begin
        if (!ui_clk_sync_rst_i && app_rd_data_valid_i) assert (!tag_empty);
    end
`endif

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// Table-driven bench for bsg_dmc_ui_arbiter with a read-routing scoreboard.
module tb_bsg_dmc_ui_arbiter;

    localparam logic [2:0] RD = 3'b001;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D1 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [7:0]  M0 = 8'h0F;
    localparam logic [7:0]  M1 = 8'hF0;
`ifdef BSG_DMC_UI_ARB_FIXED_PRIORITY_EN
    localparam bit fixed_lp = 1'b1;
`else
    localparam bit fixed_lp = 1'b0;
`endif

    logic         ui_clk_i = 1'b0;
    logic         ui_clk_sync_rst_i;
    logic [1:0]   req_v_i;
    logic [5:0]   req_cmd_i;
    logic [55:0]  req_addr_i;
    logic [1:0]   req_ready_o;
    logic [1:0]   wdata_v_i;
    logic [127:0] wdata_i;
    logic [15:0]  wmask_i;
    logic [1:0]   wdata_ready_o;
    logic [1:0]   rdata_v_o;
    logic [63:0]  rdata_o;
    logic         rdata_end_o;
    logic [27:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o;
    logic         app_rdy_i;
    logic         app_wdf_wren_o;
    logic [63:0]  app_wdf_data_o;
    logic [7:0]   app_wdf_mask_o;
    logic         app_wdf_end_o;
    logic         app_wdf_rdy_i;
    logic         app_rd_data_valid_i;
    logic [63:0]  app_rd_data_i;
    logic         app_rd_data_end_i;

    bsg_dmc_ui_arbiter #(
        .num_ports_p(2), .ui_addr_width_p(28), .ui_data_width_p(64),
        .burst_data_width_p(256), .tag_fifo_els_p(4)
    ) dut (
        .ui_clk_i(ui_clk_i), .ui_clk_sync_rst_i(ui_clk_sync_rst_i),
        .req_v_i(req_v_i), .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
        .wdata_v_i(wdata_v_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .wdata_ready_o(wdata_ready_o),
        .rdata_v_o(rdata_v_o), .rdata_o(rdata_o), .rdata_end_o(rdata_end_o),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
        .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_data_end_i(app_rd_data_end_i)
    );

    always #5 ui_clk_i = ~ui_clk_i;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [2:0]  c0;
        logic [27:0] a0;
        logic [2:0]  c1;
        logic [27:0] a1;
        logic        rdy;
        logic [1:0]  wv;
        logic        wrdy;
        logic        en;
        logic [27:0] addr;
        logic [1:0]  rr;
        logic [1:0]  wr;
        logic        wren;
        logic        wend;
        logic        wp;
    } vec_t;

    vec_t tbl[$];
    int   exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic rst, input logic [1:0] req,
                                input logic [2:0] c0, input logic [27:0] a0,
                                input logic [2:0] c1, input logic [27:0] a1,
                                input logic rdy, input logic [1:0] wv, input logic wrdy,
                                input logic en, input logic [27:0] addr, input logic [1:0] rr,
                                input logic [1:0] wr, input logic wren, input logic wend,
                                input logic wp);
        vec_t t;
        t.rst = rst; t.req = req; t.c0 = c0; t.a0 = a0; t.c1 = c1; t.a1 = a1;
        t.rdy = rdy; t.wv = wv; t.wrdy = wrdy; t.en = en; t.addr = addr; t.rr = rr;
        t.wr = wr; t.wren = wren; t.wend = wend; t.wp = wp;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ui_clk_sync_rst_i = 1'b1;
        req_v_i = '0; wdata_v_i = '0; app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
        app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0; app_rd_data_i = '0;
        repeat (2) @(posedge ui_clk_i);
        #1;
        ui_clk_sync_rst_i = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t t);
        int p;
        ui_clk_sync_rst_i = t.rst;
        req_v_i = t.req;
        req_cmd_i = {t.c1, t.c0};
        req_addr_i = {t.a1, t.a0};
        app_rdy_i = t.rdy;
        wdata_v_i = t.wv;
        app_wdf_rdy_i = t.wrdy;
        @(negedge ui_clk_i);
        check($sformatf("row%0d app_en", idx), 64'(app_en_o), 64'(t.en));
        check($sformatf("row%0d req_ready", idx), 64'(req_ready_o), 64'(t.rr));
        check($sformatf("row%0d wdata_ready", idx), 64'(wdata_ready_o), 64'(t.wr));
        check($sformatf("row%0d wdf_wren", idx), 64'(app_wdf_wren_o), 64'(t.wren));
        check($sformatf("row%0d wdf_end", idx), 64'(app_wdf_end_o), 64'(t.wend));
        check($sformatf("row%0d rdata_v", idx), 64'(rdata_v_o), 64'd0);
        if (t.en) check($sformatf("row%0d app_addr", idx), 64'(app_addr_o), 64'(t.addr));
        if (t.wren) begin
            check($sformatf("row%0d wdf_data", idx), app_wdf_data_o, t.wp ? D1 : D0);
            check($sformatf("row%0d wdf_mask", idx), 64'(app_wdf_mask_o), 64'(t.wp ? M1 : M0));
        end
        if (t.rr != 2'b00) begin
            p = t.rr[1] ? 1 : 0;
            if ((t.rr[1] ? t.c1 : t.c0) == RD) exp_q.push_back(p);
        end
        @(posedge ui_clk_i);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply(i, tbl[i]);
    endtask

    task automatic return_burst(input bit hold);
        int p;
        logic [63:0] d;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got no pending read, expected one");
            return;
        end
        p = exp_q.pop_front();
        for (int b = 0; b < 4; b++) begin
            d = {$urandom, $urandom};
            app_rd_data_valid_i = 1'b1;
            app_rd_data_end_i = (b == 3);
            app_rd_data_i = d;
            @(negedge ui_clk_i);
            check($sformatf("rd port%0d beat%0d rdata_v", p, b), 64'(rdata_v_o), 64'd1 << p);
            check($sformatf("rd port%0d beat%0d rdata", p, b), rdata_o, d);
            check($sformatf("rd port%0d beat%0d rdata_end", p, b), 64'(rdata_end_o), 64'(b == 3));
            if (hold) check($sformatf("blocked rd beat%0d app_en", b), 64'(app_en_o), 64'd0);
            @(posedge ui_clk_i);
            #1;
        end
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i = 1'b0;
        app_rd_data_i = '0;
    endtask

    initial begin
        int s1, s2, s3, s4, s5, s6;
        logic [27:0] a1p;
        logic [1:0]  r1p;
        a1p = fixed_lp ? 28'h200 : 28'h300;
        r1p = fixed_lp ? 2'b01 : 2'b10;

        wdata_i = {D1, D0};
        wmask_i = {M1, M0};
        req_cmd_i = '0;
        req_addr_i = '0;

        // single read from port 0
        s1 = tbl.size();
        add(0, 2'b01, RD, 'h100, RD, 0, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b01, RD, 'h100, RD, 0, 1, 2'b00, 0, 1, 'h100, 2'b01, 2'b00, 0, 0, 0);
        add(0, 2'b00, RD, 'h100, RD, 0, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        // both ports reading: alternate grants, fill FIFO, then a blocked fifth read
        s2 = tbl.size();
        for (int k = 0; k < 2; k++) begin
            add(0, 2'b11, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
            add(0, 2'b11, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 1, 'h200, 2'b01, 2'b00, 0, 0, 0);
            add(0, 2'b11, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
            add(0, 2'b11, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 1, a1p, r1p, 2'b00, 0, 0, 0);
        end
        add(0, 2'b01, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b01, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b01, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        s3 = tbl.size();
        add(0, 2'b01, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 1, 'h200, 2'b01, 2'b00, 0, 0, 0);
        add(0, 2'b00, RD, 'h200, RD, 'h300, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        // port 1 write burst with app_wdf_rdy_i toggling while port 0 waits
        s4 = tbl.size();
        add(0, 2'b10, RD, 'h500, WR, 'h400, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b00, 0, 1, 'h400, 2'b10, 2'b00, 0, 0, 0);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 0, 1);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 0, 1);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 0, 1);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1);
        add(0, 2'b11, RD, 'h500, WR, 'h400, 1, 2'b10, 1, 0, 0, 2'b00, 2'b10, 1, 1, 1);
        add(0, 2'b01, RD, 'h500, WR, 'h400, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b01, RD, 'h500, WR, 'h400, 1, 2'b00, 0, 1, 'h500, 2'b01, 2'b00, 0, 0, 0);
        add(0, 2'b00, RD, 'h500, WR, 'h400, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        // app_rdy_i low for 10 cycles in CMD, then reset in the middle of the burst
        s5 = tbl.size();
        add(0, 2'b01, WR, 'h600, RD, 'h700, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            add(0, 2'b11, WR, 'h600, RD, 'h700, 0, 2'b00, 0, 1, 'h600, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b11, WR, 'h600, RD, 'h700, 1, 2'b00, 0, 1, 'h600, 2'b01, 2'b00, 0, 0, 0);
        add(0, 2'b11, WR, 'h600, RD, 'h700, 1, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 0, 0);
        add(1, 2'b11, WR, 'h600, RD, 'h700, 1, 2'b01, 1, 0, 0, 2'b00, 2'b01, 1, 0, 0);
        add(0, 2'b11, WR, 'h600, RD, 'h700, 0, 2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        add(0, 2'b11, WR, 'h600, RD, 'h700, 0, 2'b00, 0, 1, 'h600, 2'b00, 2'b00, 0, 0, 0);
        s6 = tbl.size();

        do_reset();
        @(negedge ui_clk_i);
        check("reset app_en", 64'(app_en_o), 64'd0);
        check("reset req_ready", 64'(req_ready_o), 64'd0);
        check("reset wdata_ready", 64'(wdata_ready_o), 64'd0);
        check("reset rdata_v", 64'(rdata_v_o), 64'd0);
        check("reset wdf_wren", 64'(app_wdf_wren_o), 64'd0);
        check("reset wdf_end", 64'(app_wdf_end_o), 64'd0);
        check("reset app_addr", 64'(app_addr_o), 64'd0);
        check("reset wdf_data", app_wdf_data_o, 64'd0);
        @(posedge ui_clk_i);
        #1;

        run_rows(s1, s2);
        return_burst(1'b0);

        do_reset();
        run_rows(s2, s3);
        return_burst(1'b1);
        run_rows(s3, s4);
        repeat (4) return_burst(1'b0);

        do_reset();
        run_rows(s4, s5);
        return_burst(1'b0);
        run_rows(s5, s6);

        do_reset();
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
